// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
// seg_scan_capture : seven-segment scan-bus monitor, decodes stable glyphs
// Revision 1.0
// ============================================================================
module seg_scan_capture #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_DIGITS-1:0]   an,
    input  logic [6:0]            seg,
    input  logic                  clr_err,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   valid,
    output logic                  frame_done,
    output logic                  glyph_err
);

    localparam logic [CNT_W-1:0] c_STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_PRE    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0]       c_BLANK  = 7'h7F;

    logic [N_DIGITS-1:0]   r_s1_an;
    logic [6:0]            r_s1_seg;
    logic [N_DIGITS-1:0]   r_held_an;
    logic [6:0]            r_held_seg;
    logic [CNT_W-1:0]      r_cnt;
    logic [4*N_DIGITS-1:0] r_digits;
    logic [N_DIGITS-1:0]   r_valid;
    logic                  r_frame_done;
    logic                  r_glyph_err;

    logic [N_DIGITS-1:0]   w_low;
    logic                  w_sel;
    logic                  w_match;
    logic                  w_commit;
    logic                  w_legal;
    logic                  w_blank;
    logic [3:0]            w_nib;

    // Selectable means exactly one anode low: non-zero and a power of two.
    assign w_low    = ~r_s1_an;
    assign w_sel    = (w_low != '0) && ((w_low & (w_low - 1'b1)) == '0);
    assign w_match  = ({r_s1_an, r_s1_seg} == {r_held_an, r_held_seg});
    assign w_commit = w_sel && w_match && (r_cnt == c_PRE);
    assign w_blank  = (r_s1_seg == c_BLANK);

    always_comb begin
        w_nib   = 4'h0;
        w_legal = 1'b1;
        case (r_s1_seg)
            7'h40:   w_nib = 4'h0;
            7'h79:   w_nib = 4'h1;
            7'h24:   w_nib = 4'h2;
            7'h30:   w_nib = 4'h3;
            7'h19:   w_nib = 4'h4;
            7'h12:   w_nib = 4'h5;
            7'h02:   w_nib = 4'h6;
            7'h78:   w_nib = 4'h7;
            7'h00:   w_nib = 4'h8;
            7'h10:   w_nib = 4'h9;
            7'h08:   w_nib = 4'hA;
            7'h03:   w_nib = 4'hB;
            7'h46:   w_nib = 4'hC;
            7'h21:   w_nib = 4'hD;
            7'h06:   w_nib = 4'hE;
            7'h0E:   w_nib = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_an    <= '0;
            r_s1_seg   <= '0;
            r_held_an  <= '0;
            r_held_seg <= '0;
            r_cnt      <= '0;
        end else begin
            r_s1_an  <= an;
            r_s1_seg <= seg;
            if (w_sel && w_match) begin
                if (r_cnt != c_STABLE) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_sel) begin
                r_held_an  <= r_s1_an;
                r_held_seg <= r_s1_seg;
                r_cnt      <= CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // At commit s1 equals the held pattern, so the low anode is the slot one-hot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits     <= '0;
            r_valid      <= '0;
            r_frame_done <= 1'b0;
            r_glyph_err  <= 1'b0;
        end else begin
            r_frame_done <= w_commit && w_low[N_DIGITS-1];
            for (int i = 0; i < N_DIGITS; i++) begin
                if (w_commit && w_low[i]) begin
                    if (w_legal) begin
                        r_digits[4*i +: 4] <= w_nib;
                        r_valid[i]         <= 1'b1;
                    end else if (w_blank) begin
                        r_valid[i] <= 1'b0;
                    end
                end
            end
            if (w_commit && !w_legal && !w_blank) begin
                r_glyph_err <= 1'b1;
            end else if (clr_err) begin
                r_glyph_err <= 1'b0;
            end
        end
    end

    assign digits     = r_digits;
    assign valid      = r_valid;
    assign frame_done = r_frame_done;
    assign glyph_err  = r_glyph_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_capture : directed + random check against a run-length model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_seg_scan_capture;

    localparam int N = 4;
    localparam int S = 4;
    localparam logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_err;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        frame_done;
    logic        glyph_err;

    int total = 0;
    int bad   = 0;
    int dut_fd = 0;

    logic [10:0] m_s1;
    logic [10:0] run_val;
    int          run_len;
    logic [3:0]  m_dig [4];
    logic [3:0]  m_val;
    logic        m_fd;
    logic        m_err;

    always #5 clk = ~clk;

    seg_scan_capture #(.N_DIGITS(N), .STABLE_CYCLES(S), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .clr_err(clr_err),
        .digits(digits), .valid(valid), .frame_done(frame_done), .glyph_err(glyph_err)
    );

    function automatic int glyph_idx(logic [6:0] p);
        for (int i = 0; i < 16; i++) if (GL[i] == p) return i;
        return -1;
    endfunction

    function automatic bit one_low(logic [3:0] a);
        return $countones(~a) == 1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; run_val = '0; run_len = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_val = '0; m_fd = 1'b0; m_err = 1'b0;
    endtask

    // A commit happens when a run of identical selectable samples reaches length S.
    task automatic model_edge(logic [3:0] a, logic [6:0] s, logic c);
        bit err_set;
        int gi;
        int slot;
        err_set = 1'b0;
        m_fd = 1'b0;
        if (one_low(m_s1[10:7])) begin
            if (run_len > 0 && m_s1 == run_val) run_len++;
            else begin run_val = m_s1; run_len = 1; end
            if (run_len == S) begin
                slot = 0;
                for (int i = 0; i < 4; i++) if (!m_s1[7+i]) slot = i;
                gi = glyph_idx(m_s1[6:0]);
                if (gi >= 0) begin
                    m_dig[slot] = gi[3:0];
                    m_val[slot] = 1'b1;
                end else if (m_s1[6:0] == 7'h7F) begin
                    m_val[slot] = 1'b0;
                end else begin
                    err_set = 1'b1;
                end
                if (slot == 3) m_fd = 1'b1;
            end
        end else begin
            run_len = 0;
        end
        if (err_set) m_err = 1'b1;
        else if (c) m_err = 1'b0;
        m_s1 = {a, s};
    endtask

    task automatic cyc(logic [3:0] a, logic [6:0] s, logic c);
        an = a; seg = s; clr_err = c;
        @(posedge clk);
        model_edge(a, s, c);
        #1;
        if (frame_done) dut_fd++;
        chk("digits", digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
        chk("valid", valid, m_val);
        chk("frame_done", frame_done, m_fd);
        chk("glyph_err", glyph_err, m_err);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_digits", digits, 0);
        chk("rst_valid", valid, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", glyph_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int f0;
        logic [3:0] a;
        logic [6:0] s;
        int hold;
        int pick;
        rst = 1'b1; an = 4'hF; seg = 7'h7F; clr_err = 1'b0;
        model_reset();
        #1;
        chk("init_digits", digits, 0);
        chk("init_valid", valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Slot 0 glyph 2: commits on the fifth edge, not before.
        for (int k = 1; k <= 8; k++) begin
            cyc(4'b1110, 7'h24, 1'b0);
            if (k == 4) chk("pre_commit_valid0", valid[0], 0);
            if (k == 5) begin
                chk("commit_dig0", digits[3:0], 4'h2);
                chk("commit_valid", valid, 4'b0001);
            end
        end

        // Async reset part-way through a run on slot 1.
        repeat (4) cyc(4'b1101, 7'h79, 1'b0);
        async_reset();
        chk("post_rst_digits", digits, 0);
        repeat (4) cyc(4'b1101, 7'h79, 1'b0);
        chk("fresh_run_pending", valid[1], 0);
        cyc(4'b1101, 7'h79, 1'b0);
        chk("fresh_run_commit", digits[7:4], 4'h1);

        // Slot 3: a 3-sample run is discarded, a full run commits with one frame_done.
        repeat (3) cyc(4'b0111, 7'h0E, 1'b0);
        cyc(4'b1111, 7'h7F, 1'b0);
        cyc(4'b1111, 7'h7F, 1'b0);
        chk("short_run_none", valid[3], 0);
        f0 = dut_fd;
        repeat (6) cyc(4'b0111, 7'h0E, 1'b0);
        repeat (2) cyc(4'b1111, 7'h7F, 1'b0);
        chk("slot3_F", digits[15:12], 4'hF);
        chk("slot3_valid", valid[3], 1);
        chk("slot3_frames", dut_fd - f0, 1);

        // Two full scan frames with gaps.
        f0 = dut_fd;
        for (int fr = 0; fr < 2; fr++) begin
            for (int sl = 0; sl < 4; sl++) begin
                a = 4'b1111; a[sl] = 1'b0;
                case (sl)
                    0: s = 7'h79;
                    1: s = 7'h08;
                    2: s = 7'h03;
                    default: s = 7'h10;
                endcase
                repeat (4) cyc(a, s, 1'b0);
                repeat (2) cyc(4'b1111, 7'h7F, 1'b0);
            end
        end
        chk("scan_digits", digits, 16'h9BA1);
        chk("scan_valid", valid, 4'b1111);
        chk("scan_frames", dut_fd - f0, 2);

        // Illegal glyph, clear, then clear coincident with a new illegal commit.
        repeat (4) cyc(4'b1101, 7'h55, 1'b0);
        cyc(4'b1111, 7'h7F, 1'b0);
        chk("illegal_err", glyph_err, 1);
        chk("illegal_keep", digits[7:4], 4'hA);
        cyc(4'b1111, 7'h7F, 1'b1);
        chk("clr_err", glyph_err, 0);
        repeat (4) cyc(4'b1101, 7'h55, 1'b0);
        cyc(4'b1111, 7'h7F, 1'b1);
        chk("set_beats_clr", glyph_err, 1);

        // Two low anodes never commit; blank on slot 2 clears only its valid bit.
        cyc(4'b1111, 7'h7F, 1'b1);
        repeat (10) cyc(4'b1100, 7'h24, 1'b0);
        chk("ghost_err", glyph_err, 0);
        chk("ghost_digits", digits, 16'h9BA1);
        repeat (5) cyc(4'b1011, 7'h7F, 1'b0);
        chk("blank_valid", valid, 4'b1011);
        chk("blank_digits", digits[11:8], 4'hB);

        // Random runs of mixed slots, glyphs, blanks, illegal patterns and ghosts.
        for (int r = 0; r < 120; r++) begin
            pick = int'($urandom_range(0, 5));
            a = 4'b1111;
            if (pick < 4) a[pick] = 1'b0;
            else if (pick == 5) a = 4'($urandom_range(0, 15));
            pick = int'($urandom_range(0, 19));
            if (pick < 14) s = GL[pick];
            else if (pick < 17) s = 7'h7F;
            else s = 7'($urandom_range(0, 127));
            hold = int'($urandom_range(1, 7));
            for (int h = 0; h < hold; h++) cyc(a, s, ($urandom_range(0, 9) == 0));
            if (r == 60) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
